sm83_bus_ctrl: RTL and testbench

- External memory bus controller for the SM83 core. Sits directly downstream of the M/T-cycle sequencer and consumes its one-hot t1..t4 strobes.
- Turns one core memory request per M-cycle into a 4-T-state bus cycle: address, chip select, read/write strobes, data output enable, and read-data capture.
- The core issues requests during an M-cycle; the block executes them in the following M-cycle.

---
 rtl/sm83_bus_ctrl_if.sv | 45 ++++
 rtl/sm83_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_sm83_bus_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sm83_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sm83_bus_ctrl_if
// Brief    : Strobe, request and external-bus bundle for sm83_bus_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface sm83_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  t1;
  logic                  t2;
  logic                  t3;
  logic                  t4;
  logic                  req_rd;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] d_in;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  d_oe;
  logic                  cs_n;
  logic                  rd_n;
  logic                  wr_n;
  logic                  busy;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  bus_err;
  logic [ADDR_WIDTH-1:0] dbg_last_addr;
  logic [15:0]           dbg_cycles;

  modport master (
    output t1, t2, t3, t4, req_rd, req_wr, req_addr, req_wdata, d_in,
    input  a, d_out, d_oe, cs_n, rd_n, wr_n, busy, rdata, rdata_valid,
           bus_err, dbg_last_addr, dbg_cycles
  );

  modport slave (
    input  t1, t2, t3, t4, req_rd, req_wr, req_addr, req_wdata, d_in,
    output a, d_out, d_oe, cs_n, rd_n, wr_n, busy, rdata, rdata_valid,
           bus_err, dbg_last_addr, dbg_cycles
  );
endinterface
`default_nettype wire

// File: rtl/sm83_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sm83_bus_ctrl
// Brief    : SM83 external memory bus controller; one 4-T-state bus cycle per
//            M-cycle. Optional debug counters enabled by SM83_BUS_DBG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sm83_bus_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic      clk,
  input  wire logic      reset,
  sm83_bus_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_d_out;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_d_oe;
  logic                  r_cs_n;
  logic                  r_rd_n;
  logic                  r_wr_n;
  logic                  r_busy;
  logic                  r_rdata_valid;
  logic                  r_bus_err;

  logic                  w_load_a;
  logic                  w_set_err;
  logic                  w_load_dout;
  logic                  w_d_oe;
  logic                  w_cs_n;
  logic                  w_rd_n;
  logic                  w_wr_n;
  logic                  w_busy;
  logic                  w_rdata_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_set_err   = 1'b0;
    if (bus.t4) begin
      if (bus.req_rd) begin
        w_state_nxt = S_READ;
        w_load_a    = 1'b1;
        w_set_err   = bus.req_wr;
      end else if (bus.req_wr) begin
        w_state_nxt = S_WRITE;
        w_load_a    = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end

    // Values are those of the T-state being entered (t4 edge -> t1, t1 -> t2, ...)
    w_busy        = (w_state_nxt != S_IDLE);
    w_cs_n        = !w_busy;
    w_rd_n        = (w_state_nxt != S_READ);
    w_wr_n        = !((w_state_nxt == S_WRITE) && (bus.t1 || bus.t2));
    w_d_oe        = (w_state_nxt == S_WRITE) && !bus.t4;
    w_rdata_valid = (r_state == S_READ) && bus.t3;
    w_load_dout   = (r_state == S_WRITE) && bus.t1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a           <= '0;
      r_wdata       <= '0;
      r_d_out       <= '0;
      r_rdata       <= '0;
      r_d_oe        <= 1'b0;
      r_cs_n        <= 1'b1;
      r_rd_n        <= 1'b1;
      r_wr_n        <= 1'b1;
      r_busy        <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      r_d_oe        <= w_d_oe;
      r_cs_n        <= w_cs_n;
      r_rd_n        <= w_rd_n;
      r_wr_n        <= w_wr_n;
      r_busy        <= w_busy;
      r_rdata_valid <= w_rdata_valid;
      if (w_load_a) begin
        r_a     <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (w_load_dout)   r_d_out   <= r_wdata;
      if (w_rdata_valid) r_rdata   <= bus.d_in;
      if (w_set_err)     r_bus_err <= 1'b1;
    end
  end

  assign bus.a           = r_a;
  assign bus.d_out       = r_d_out;
  assign bus.d_oe        = r_d_oe;
  assign bus.cs_n        = r_cs_n;
  assign bus.rd_n        = r_rd_n;
  assign bus.wr_n        = r_wr_n;
  assign bus.busy        = r_busy;
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.bus_err     = r_bus_err;

`ifdef SM83_BUS_DBG_EN
  logic [ADDR_WIDTH-1:0] r_dbg_last_addr;
  logic [15:0]           r_dbg_cycles;
  logic                  w_cycle_end;

  assign w_cycle_end = bus.t4 && (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg_last_addr <= '0;
      r_dbg_cycles    <= '0;
    end else if (w_cycle_end) begin
      r_dbg_last_addr <= r_a;
      r_dbg_cycles    <= r_dbg_cycles + 16'd1;
    end
  end

  assign bus.dbg_last_addr = r_dbg_last_addr;
  assign bus.dbg_cycles    = r_dbg_cycles;
`else
  assign bus.dbg_last_addr = '0;
  assign bus.dbg_cycles    = '0;
`endif

`ifdef FORMAL
  always_comb assume ($onehot({bus.t1, bus.t2, bus.t3, bus.t4}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm83_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm83_bus_ctrl
// Brief    : Randomized self-checking bench for sm83_bus_ctrl against a
//            per-bus-cycle reference model (honours SM83_BUS_DBG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm83_bus_ctrl;

  localparam int K_IDLE  = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;

  logic clk;
  logic reset;

  sm83_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_if ();

  sm83_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int next_ph;
  int cnt_cs, cnt_rd, cnt_wr;

  // Reference model: what kind of bus cycle is running and which T-state we are in
  int          m_kind;
  int          m_pos;
  logic [15:0] m_a;
  logic [7:0]  m_wlat;
  logic [7:0]  m_dout;
  logic [7:0]  m_rdata;
  logic        m_err;
  logic [15:0] m_dbg_cnt;
  logic [15:0] m_dbg_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind     = K_IDLE;
    m_pos      = 1;
    m_a        = '0;
    m_wlat     = '0;
    m_dout     = '0;
    m_rdata    = '0;
    m_err      = 1'b0;
    m_dbg_cnt  = '0;
    m_dbg_addr = '0;
  endtask

  task automatic model_edge(input int p, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] din);
    if (p == 1 && m_kind == K_WRITE) m_dout  = m_wlat;
    if (p == 3 && m_kind == K_READ)  m_rdata = din;
    if (p == 4) begin
`ifdef SM83_BUS_DBG_EN
      if (m_kind != K_IDLE) begin
        m_dbg_cnt  = m_dbg_cnt + 16'd1;
        m_dbg_addr = m_a;
      end
`endif
      if (rd || wr) begin
        m_kind = rd ? K_READ : K_WRITE;
        m_a    = addr;
        m_wlat = wd;
        if (rd && wr) m_err = 1'b1;
      end else begin
        m_kind = K_IDLE;
      end
      m_pos = 1;
    end else begin
      m_pos = p + 1;
    end
  endtask

  task automatic check_outputs();
    logic e_wr_low;
    logic e_oe;
    e_wr_low = (m_kind == K_WRITE) && (m_pos == 2 || m_pos == 3);
    e_oe     = (m_kind == K_WRITE) && (m_pos >= 2);
    check("a",           32'(bus_if.a),             32'(m_a));
    check("d_out",       32'(bus_if.d_out),         32'(m_dout));
    check("d_oe",        32'(bus_if.d_oe),          32'(e_oe));
    check("cs_n",        32'(bus_if.cs_n),          32'(m_kind == K_IDLE));
    check("rd_n",        32'(bus_if.rd_n),          32'(m_kind != K_READ));
    check("wr_n",        32'(bus_if.wr_n),          32'(!e_wr_low));
    check("busy",        32'(bus_if.busy),          32'(m_kind != K_IDLE));
    check("rdata",       32'(bus_if.rdata),         32'(m_rdata));
    check("rdata_valid", 32'(bus_if.rdata_valid),   32'(m_kind == K_READ && m_pos == 4));
    check("bus_err",     32'(bus_if.bus_err),       32'(m_err));
    check("dbg_addr",    32'(bus_if.dbg_last_addr), 32'(m_dbg_addr));
    check("dbg_cycles",  32'(bus_if.dbg_cycles),    32'(m_dbg_cnt));
    if (!bus_if.cs_n) cnt_cs++;
    if (!bus_if.rd_n) cnt_rd++;
    if (!bus_if.wr_n) cnt_wr++;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [15:0] addr, input logic [7:0] wd);
    int p;
    logic [7:0] din;
    p   = next_ph;
    din = 8'($urandom);
    bus_if.t1        = (p == 1);
    bus_if.t2        = (p == 2);
    bus_if.t3        = (p == 3);
    bus_if.t4        = (p == 4);
    bus_if.req_rd    = rd;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wd;
    bus_if.d_in      = din;
    @(posedge clk);
    model_edge(p, rd, wr, addr, wd, din);
    next_ph = (p == 4) ? 1 : p + 1;
    @(negedge clk);
    check_outputs();
  endtask

  // Non-t4 clocks carry random request noise that the DUT must ignore
  task automatic mcycle(input logic rd, input logic wr, input logic [15:0] addr, input logic [7:0] wd);
    while (next_ph != 4)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
    step(rd, wr, addr, wd);
  endtask

  task automatic reset_pulse();
    #1 reset = 1'b1;
    #1 model_reset();
    check_outputs();
    #1 reset = 1'b0;
  endtask

  task automatic random_mcycle();
    int r;
    logic rd, wr;
    r  = int'($urandom_range(0, 19));
    rd = (r < 8) || (r == 19);
    wr = (r >= 8 && r < 14) || (r == 19);
    mcycle(rd, wr, 16'($urandom), 8'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    next_ph = 1;
    cnt_cs = 0; cnt_rd = 0; cnt_wr = 0;
    bus_if.t1 = 1'b0; bus_if.t2 = 1'b0; bus_if.t3 = 1'b0; bus_if.t4 = 1'b0;
    bus_if.req_rd = 1'b0; bus_if.req_wr = 1'b0;
    bus_if.req_addr = '0; bus_if.req_wdata = '0; bus_if.d_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Single read and single write, each followed by an idle M-cycle
    mcycle(1'b1, 1'b0, 16'hC123, 8'h00);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00);
    mcycle(1'b0, 1'b1, 16'hFF40, 8'h91);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00);
    check("wr_dout", 32'(bus_if.d_out), 32'h91);

    // Back-to-back: read, read, write
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00);
    cnt_cs = 0; cnt_rd = 0; cnt_wr = 0;
    mcycle(1'b1, 1'b0, 16'h0100, 8'h00);
    mcycle(1'b1, 1'b0, 16'h0101, 8'h00);
    mcycle(1'b0, 1'b1, 16'h8000, 8'h3C);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00);
    check("b2b_cs_low", 32'(cnt_cs), 32'd12);
    check("b2b_rd_low", 32'(cnt_rd), 32'd8);
    check("b2b_wr_low", 32'(cnt_wr), 32'd2);

    // Conflicting request: read wins, sticky error
    mcycle(1'b1, 1'b1, 16'hC000, 8'h55);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00);
    check("err_sticky", 32'(bus_if.bus_err), 32'd1);

    // Reset while in t2 of a write, then a normal request afterwards
    mcycle(1'b0, 1'b1, 16'h4444, 8'hAA);
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    reset_pulse();
    mcycle(1'b1, 1'b0, 16'h2222, 8'h00);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00);

    for (int i = 0; i < 200; i++) random_mcycle();
    repeat (int'($urandom_range(0, 3))) step(1'b0, 1'b0, 16'h0000, 8'h00);
    reset_pulse();
    for (int i = 0; i < 200; i++) random_mcycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
